// File: rtl/imm_extend_unit.sv
// Immediate extension unit: zero/sign/load-upper extension and a two-beat concatenation
// mode, with a single registered output stage under valid/ready flow control.
module imm_extend_unit #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] extended,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             pending,
  output logic             abort
);

  if (OUT_W < 2 * IN_W) begin : gen_width_check
    $error("imm_extend_unit: OUT_W must be at least 2*IN_W");
  end

  localparam logic [1:0] ModeZero   = 2'b00;
  localparam logic [1:0] ModeSign   = 2'b01;
  localparam logic [1:0] ModeUpper  = 2'b10;
  localparam logic [1:0] ModeConcat = 2'b11;

  typedef enum logic [0:0] {StIdle, StHaveHi} state_e;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  hi_q, hi_d;
  logic [OUT_W-1:0] ext_q, ext_d;
  logic             out_valid_q, out_valid_d;
  logic             abort_q, abort_d;
  logic             accept;
  logic             load;
  logic [OUT_W-1:0] result;

  // Single output register: a draining result frees the slot in the same cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    result = '0;
    unique case (mode)
      ModeZero:   result = OUT_W'(in);
      ModeSign:   result = OUT_W'($signed(in));
      ModeUpper:  result = OUT_W'(in) << (OUT_W - IN_W);
      ModeConcat: result = (OUT_W'(hi_q) << IN_W) | OUT_W'(in);
      default:    result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    load    = 1'b0;
    abort_d = 1'b0;
    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (mode == ModeConcat) begin
            hi_d    = in;
            state_d = StHaveHi;
          end else begin
            load = 1'b1;
          end
        end
        StHaveHi: begin
          // Any mode other than concat drops the held high beat and is processed on its own.
          load    = 1'b1;
          state_d = StIdle;
          hi_d    = '0;
          abort_d = (mode != ModeConcat);
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    ext_d       = ext_q;
    out_valid_d = out_valid_q;
    if (load) begin
      ext_d       = result;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hi_q        <= '0;
      ext_q       <= '0;
      out_valid_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      ext_q       <= ext_d;
      out_valid_q <= out_valid_d;
      abort_q     <= abort_d;
    end
  end

  assign extended  = ext_q;
  assign out_valid = out_valid_q;
  assign pending   = (state_q == StHaveHi);
  assign abort     = abort_q;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit with an expected-result queue.
module tb_imm_extend_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  mode;
  logic [15:0] extended;
  logic        out_valid;
  logic        out_ready;
  logic        pending;
  logic        abort;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  imm_extend_unit #(.IN_W(8), .OUT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_data),
    .mode      (mode),
    .extended  (extended),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  // Offers one beat, waits (bounded) for acceptance, returns at the negedge after the accept edge.
  task automatic send(input logic [1:0] m, input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    mode     = m;
    in_data  = d;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({extended, out_valid, pending, abort, in_ready} !== {16'h0, 4'b0001}) begin
      n_errors++;
      $display("FAIL reset_state ext=%h ov=%b pend=%b abort=%b rdy=%b required 0000 0 0 0 1",
               extended, out_valid, pending, abort, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_ext();
    logic [7:0] vals [4] = '{8'd0, 8'd97, 8'd128, 8'd223};
    foreach (vals[i]) begin
      exp_q.push_back({8'h00, vals[i]});
      send(2'b00, vals[i]);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || extended !== exp_v) begin
        n_errors++;
        $display("FAIL zero_ext[%0d] ov=%b ext=%h required ov=1 ext=%h", i, out_valid, extended, exp_v);
      end
    end
  endtask

  task automatic test_sign_upper();
    logic [1:0] modes [3] = '{2'b01, 2'b01, 2'b10};
    logic [7:0] vals  [3] = '{8'h80, 8'h7F, 8'hDF};
    logic [15:0] exps [3] = '{16'hFF80, 16'h007F, 16'hDF00};
    foreach (vals[i]) begin
      exp_q.push_back(exps[i]);
      send(modes[i], vals[i]);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || extended !== exp_v) begin
        n_errors++;
        $display("FAIL sign_upper[%0d] ov=%b ext=%h required ov=1 ext=%h", i, out_valid, extended, exp_v);
      end
    end
  endtask

  task automatic test_concat(input logic [7:0] hi, input logic [7:0] lo);
    send(2'b11, hi);
    n_checks++;
    if (pending !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL concat_hi pend=%b ov=%b required pend=1 ov=0", pending, out_valid);
    end
    exp_q.push_back({hi, lo});
    send(2'b11, lo);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || extended !== exp_v || pending !== 1'b0 || abort !== 1'b0) begin
      n_errors++;
      $display("FAIL concat_result ov=%b ext=%h pend=%b abort=%b required 1 %h 0 0",
               out_valid, extended, pending, abort, exp_v);
    end
  endtask

  task automatic test_abort();
    send(2'b11, 8'hAB);
    exp_q.push_back(16'h0005);
    send(2'b00, 8'h05);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (abort !== 1'b1 || out_valid !== 1'b1 || extended !== exp_v || pending !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_pulse abort=%b ov=%b ext=%h pend=%b required 1 1 %h 0",
               abort, out_valid, extended, pending, exp_v);
    end
    @(negedge clk);
    n_checks++;
    if (abort !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_one_cycle abort=%b required 0", abort);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    exp_q.push_back(16'h0061);
    send(2'b00, 8'd97);
    in_valid = 1'b1;
    mode     = 2'b00;
    in_data  = 8'h22;
    exp_q.push_back(16'h0022);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || extended !== exp_q[0]) begin
        n_errors++;
        $display("FAIL stall[%0d] rdy=%b ov=%b ext=%h required 0 1 %h",
                 i, in_ready, out_valid, extended, exp_q[0]);
      end
      @(negedge clk);
    end
    exp_v = exp_q.pop_front();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || extended !== exp_v) begin
      n_errors++;
      $display("FAIL drain_fill ov=%b ext=%h required ov=1 ext=%h", out_valid, extended, exp_v);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL drain_clear ov=%b required 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(2'b00, 8'h33);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({extended, out_valid, pending, abort, in_ready} !== {16'h0, 4'b0001}) begin
      n_errors++;
      $display("FAIL async_reset_ov ext=%h ov=%b pend=%b abort=%b rdy=%b required 0000 0 0 0 1",
               extended, out_valid, pending, abort, in_ready);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(2'b11, 8'h9A);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (pending !== 1'b0 || out_valid !== 1'b0 || extended !== 16'h0) begin
      n_errors++;
      $display("FAIL async_reset_hi pend=%b ov=%b ext=%h required 0 0 0000", pending, out_valid, extended);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_concat(8'h56, 8'h78);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = '0;
    out_ready = 1'b1;
    test_reset();
    test_zero_ext();
    test_sign_upper();
    test_concat(8'h12, 8'h34);
    test_abort();
    test_backpressure();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty left=%0d required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
